// File: rtl/ldpc_wb_pkg.sv
// Shared types and constants for the ldpcEncDec Wishbone initiator.
package ldpc_wb_pkg;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ldpcEncDec register map.
    localparam logic [31:0] LDPC_BASE = 32'h3000_0000;
    localparam int          LDPC_MM   = 'ha8;
    localparam int          LDPC_NN   = 'hd0;
    localparam int          SUM_LEN   = 32;

    // Default ack wait bound, in cycles with stb high.
    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ldpc_wb_master_if.sv
// Wishbone classic bus between the initiator and the ldpcEncDec slave port.
interface ldpc_wb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [SEL_W-1:0]  wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [DATA_W-1:0] wbm_dat_o;
    logic              wbm_ack_i;
    logic [DATA_W-1:0] wbm_dat_i;

    // A transfer is live while cyc & stb are high; the slave answers with a
    // single-cycle ack (plus read data). adr/dat/sel/we are only meaningful
    // while cyc & stb are high.
    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/ldpc_wb_master_timeout_cnt.sv
// Saturating ack-wait counter; expired fires on the cycle whose increment
// would reach TIMEOUT. TIMEOUT = 0 disables expiry.
module wb_timeout_cnt
    import ldpc_wb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT  = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Count enabled cycles, holding at the saturation value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != SAT)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/ldpc_wb_master.sv
// Wishbone classic initiator: one outstanding single transfer per command,
// bounded ack wait, response held until consumed.
module ldpc_wb_master
    import ldpc_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic              busy,
    output state_t            dbg_state,
    ldpc_wb_master_if.master  wb
);
    state_t            state, state_n;
    logic              tmo_clr, tmo_en, tmo_expired;
    logic              cyc_q, we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_n;
    end

    // Next state, command acceptance and timeout counter control.
    always_comb begin
        state_n   = state;
        cmd_ready = (state == ST_IDLE);
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                state_n = ST_BUS;
                tmo_clr = 1'b1;
            end
            ST_BUS: begin
                tmo_en = !wb.wbm_ack_i;
                // Ack takes priority over a simultaneous expiry.
                if (wb.wbm_ack_i || tmo_expired) state_n = ST_RESP;
            end
            ST_RESP: if (rsp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Registered bus controls, request registers and response buffer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cyc_q     <= (state_n == ST_BUS);
            rsp_valid <= (state_n == ST_RESP);
            busy      <= (state_n != ST_IDLE);
            if (state == ST_IDLE && cmd_valid) begin
                we_q  <= cmd_we;
                sel_q <= cmd_sel;
                adr_q <= cmd_adr;
                dat_q <= cmd_dat;
            end
            if (state == ST_BUS) begin
                if (wb.wbm_ack_i) begin
                    rsp_dat <= we_q ? '0 : wb.wbm_dat_i;
                    rsp_err <= 1'b0;
                end else if (tmo_expired) begin
                    rsp_dat <= '0;
                    rsp_err <= 1'b1;
                end
            end
        end
    end

    assign wb.wbm_cyc_o = cyc_q;
    assign wb.wbm_stb_o = cyc_q;
    assign wb.wbm_we_o  = we_q;
    assign wb.wbm_sel_o = sel_q;
    assign wb.wbm_adr_o = adr_q;
    assign wb.wbm_dat_o = dat_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_ldpc_wb_master.sv
// Directed bench for ldpc_wb_master with a short ack timeout.
module tb_ldpc_wb_master;
    import ldpc_wb_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    state_t      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    ldpc_wb_master_if #(.ADDR_W(32), .DATA_W(32)) wb ();

    ldpc_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dbg_state (dbg_state),
        .wb        (wb.master)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command; it is accepted on the following rising edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [32:0] exp_rsp);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        exp_q.push_back(exp_rsp);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Slave model: acks in stb cycle waits+1 when ack_en, checks the request is stable.
    task automatic run_bus(input int waits, input bit ack_en, input logic [31:0] rdata,
                           input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int stb_cycles);
        stb_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wb.wbm_stb_o) break;
            stb_cycles++;
            check("bus_cyc", wb.wbm_cyc_o, 1);
            check("bus_adr", wb.wbm_adr_o, adr);
            check("bus_dat", wb.wbm_dat_o, dat);
            check("bus_sel", wb.wbm_sel_o, sel);
            check("bus_we", wb.wbm_we_o, we);
            wb.wbm_ack_i = ack_en && (stb_cycles == waits + 1);
            wb.wbm_dat_i = rdata;
        end
        wb.wbm_ack_i = 1'b0;
        check("rsp_valid_rise", rsp_valid, 1);
        check("cyc_low_resp", wb.wbm_cyc_o, 0);
    endtask

    // Consume the held response and compare against the scoreboard.
    task automatic take_rsp();
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, e[32]);
        check("rsp_dat", rsp_dat, e[31:0]);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        wb.wbm_ack_i = 1'b0;
        wb.wbm_dat_i = '0;

        // Reset.
        repeat (3) @(negedge clk);
        check("rst_cyc", wb.wbm_cyc_o, 0);
        check("rst_stb", wb.wbm_stb_o, 0);
        check("rst_we", wb.wbm_we_o, 0);
        check("rst_adr", wb.wbm_adr_o, 0);
        check("rst_dat", wb.wbm_dat_o, 0);
        check("rst_sel", wb.wbm_sel_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;

        // Write, two wait states; read-data lines are junk and must not leak.
        issue(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, {1'b0, 32'h0});
        run_bus(2, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, n);
        check("wr_stb_cycles", n, 3);
        take_rsp();

        // Zero-wait read.
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF, {1'b0, 32'h1234_5678});
        run_bus(0, 1'b1, 32'h1234_5678, 1'b0, 32'h3000_0008, 32'h0, 4'hF, n);
        check("rd0_stb_cycles", n, 1);
        take_rsp();

        // No ack: timeout after exactly TMO stb cycles.
        issue(1'b0, 32'h3000_000C, 32'h0, 4'h3, {1'b1, 32'h0});
        run_bus(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h3000_000C, 32'h0, 4'h3, n);
        check("tmo_stb_cycles", n, TMO);
        take_rsp();

        // Ack on the expiring cycle wins.
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, {1'b0, 32'hCAFE_F00D});
        run_bus(TMO - 1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h3000_0010, 32'h0, 4'hF, n);
        check("race_stb_cycles", n, TMO);
        take_rsp();

        // Held response: stray acks and a pending command change nothing.
        issue(1'b0, 32'h3000_0014, 32'h0, 4'hF, {1'b0, 32'h0BAD_BEEF});
        run_bus(1, 1'b1, 32'h0BAD_BEEF, 1'b0, 32'h3000_0014, 32'h0, 4'hF, n);
        check("hold_stb_cycles", n, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_cyc", wb.wbm_cyc_o, 0);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_dat", rsp_dat, 32'h0BAD_BEEF);
            wb.wbm_ack_i = i[0];
            wb.wbm_dat_i = 32'h5555_0000 + i;
            cmd_valid = 1'b1;
            cmd_we    = 1'b1;
            cmd_adr   = 32'h3000_0020;
        end
        cmd_valid = 1'b0;
        wb.wbm_ack_i = 1'b0;
        check("hold_adr_kept", wb.wbm_adr_o, 32'h3000_0014);
        take_rsp();

        // Asynchronous reset mid-transfer.
        issue(1'b0, 32'h3000_0018, 32'h0, 4'hF, {1'b0, 32'h0});
        void'(exp_q.pop_back());
        @(negedge clk);
        check("pre_rst_cyc", wb.wbm_cyc_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", wb.wbm_cyc_o, 0);
        check("async_rst_stb", wb.wbm_stb_o, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_state", dbg_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_wb_master.md
# ldpc_wb_master

Wishbone classic initiator that issues single read/write transfers to the `ldpcEncDec` slave port on behalf of a simple command/response stream. It sits on the host/bench side of the user-area Wishbone bus and drives `wbs_*` of the encoder/decoder. It enforces one outstanding transfer, a bounded ack wait (timeout), and a buffered response.

## Interface
- `ADDR_W`, 32, Wishbone address width.
- `DATA_W`, 32, Wishbone data width; `SEL_W = DATA_W/8`.
- `TIMEOUT`, 255, maximum cycles with `stb` high before abort; 0 disables the timeout.

- `wb_clk_i`  in  1  sole clock; all logic is rising-edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  ADDR_W  byte address.
- `cmd_dat`  in  DATA_W  write data.
- `cmd_sel`  in  SEL_W  byte enables.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_dat`  out  DATA_W  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  1 = transfer timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  Wishbone controls.
- `wbm_sel_o`  out  SEL_W;  `wbm_adr_o`  out  ADDR_W;  `wbm_dat_o`  out  DATA_W.
- `wbm_ack_i`  in  1;  `wbm_dat_i`  in  DATA_W.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `cmd_ready` = 1. On handshake, latch `we/adr/dat/sel` into the `wbm_*` registers and go to BUS.
- BUS: `cyc = stb = 1`, with address, data and sel held stable.
  - On `wbm_ack_i`: capture `wbm_dat_i` (read) or 0 (write), set `rsp_err` = 0, drop `cyc/stb`, go to RESP.
  - If the timeout counter reaches `TIMEOUT` with no ack: drop `cyc/stb`, set `rsp_dat` = 0 and `rsp_err` = 1, go to RESP.
- RESP: `rsp_valid` = 1, with `rsp_dat`/`rsp_err` stable until `rsp_ready`. On handshake, go to IDLE.
- `wbm_ack_i` is ignored outside BUS and never corrupts a held response.
- Timeout counter:
  - width `$clog2(TIMEOUT+1)`;
  - cleared on entry to BUS and incremented each BUS cycle without ack;
  - saturates, never wraps;
  - ack and timeout in the same cycle: ack wins (`rsp_err` = 0).
- `wbm_we_o`, `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` keep their last values outside BUS; only `cyc/stb` qualify them.
- Reset values: `cyc`, `stb`, `we`, `rsp_valid`, `rsp_err`, `busy` = 0; `cmd_ready` = 1; `adr`, `dat`, `sel`, `rsp_dat` = 0; state IDLE.
- Reset mid-transfer drops `cyc/stb` asynchronously. Any pending response is discarded.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state.
- Command handshake in cycle 0 → `cyc/stb` high from cycle 1.
- Ack sampled high in cycle k → `cyc/stb` low and `rsp_valid` high from cycle k+1.
- A zero-wait slave (ack in cycle 1) gives `rsp_valid` in cycle 2.
- `rsp_ready` held high → IDLE at cycle 3, so the minimum issue interval is 3 cycles.
- Timeout: with no ack, `stb` stays high for exactly `TIMEOUT` cycles (cycles 1..TIMEOUT). `rsp_valid` with `rsp_err` rises at cycle `TIMEOUT+1`.
- `cmd_ready` is 0 throughout BUS and RESP, so back-to-back commands stall until IDLE.

## Structure
- Package `ldpc_wb_pkg` holds:
  - the FSM state enum;
  - the `ldpcEncDec` register map constants: base `'h3000_0000`, code dimensions `MM = 'h a8`, `NN = 'h d0`, `SUM_LEN = 32`;
  - the default `TIMEOUT`.
- One sub-module: `wb_timeout_cnt`, a saturating counter with `clr`/`en` inputs and an `expired` output.
- The top level holds the FSM, request registers and response buffer.

## Test plan
- Write `adr = 'h3000_0004`, `dat = 'hA5A5_0001`, `sel = 'hF`, slave acks after 2 waits → `stb` high 3 cycles with stable address and data; response `rsp_dat` = 0, `rsp_err` = 0.
- Read `'h3000_0008`, slave returns `'h1234_5678` with zero wait → `rsp_valid` in cycle 2 with `rsp_dat` = `'h1234_5678`.
- No ack, `TIMEOUT` = 4 → `stb` high exactly 4 cycles; `rsp_err` = 1, `rsp_dat` = 0, `cyc` low.
- Ack arriving on the same cycle the counter expires → `rsp_err` = 0 and the data is captured.
- Hold `rsp_ready` = 0 for 10 cycles, toggle `wbm_ack_i` and offer a new command → response unchanged, `cmd_ready` = 0, no new `cyc`.
- Assert `wb_rst_i` mid-BUS → `cyc/stb` low in the same cycle without waiting for a clock edge; after release `cmd_ready` = 1, `rsp_valid` = 0.
